// File: rtl/execute_cycle.sv
// Execute stage of the RV32I pipeline: operand forwarding, ALU, branch
// resolution and the E/M pipeline register feeding the memory stage.
module execute_cycle #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            ALUSrcE,
    input  logic            MemWriteE,
    input  logic [1:0]      ResultSrcE,
    input  logic            BranchE,
    input  logic [2:0]      ALUControlE,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [4:0]      RD_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [XLEN-1:0] ResultW,
    input  logic [1:0]      ForwardA_E,
    input  logic [1:0]      ForwardB_E,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [4:0]      RD_M,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] ALU_ResultM
);

    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] fwdB;
    logic [XLEN-1:0] srcB;
    logic [XLEN-1:0] aluResult;
    logic            zeroE;

    // Operand A forward select; code 11 falls back to the register file value
    always_comb begin
        case (ForwardA_E)
            2'b01:   srcA = ResultW;
            2'b10:   srcA = ALU_ResultM;
            default: srcA = RD1_E;
        endcase
    end

    // Operand B forward select; this value is also the store data
    always_comb begin
        case (ForwardB_E)
            2'b01:   fwdB = ResultW;
            2'b10:   fwdB = ALU_ResultM;
            default: fwdB = RD2_E;
        endcase
    end

    assign srcB = ALUSrcE ? Imm_Ext_E : fwdB;

    // ALU; carries and overflow are dropped, unused codes yield zero
    always_comb begin
        aluResult = '0;
        case (ALUControlE)
            3'b000:  aluResult = srcA + srcB;
            3'b001:  aluResult = srcA - srcB;
            3'b010:  aluResult = srcA & srcB;
            3'b011:  aluResult = srcA | srcB;
            3'b101:  aluResult = {{(XLEN-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
            default: aluResult = '0;
        endcase
    end

    assign zeroE     = (aluResult == '0);
    assign PCSrcE    = BranchE & zeroE;
    assign PCTargetE = PCE + Imm_Ext_E;

    // E/M pipeline register, cleared asynchronously by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= '0;
            RD_M        <= '0;
            PCPlus4M    <= '0;
            WriteDataM  <= '0;
            ALU_ResultM <= '0;
        end else begin
            RegWriteM   <= RegWriteE;
            MemWriteM   <= MemWriteE;
            ResultSrcM  <= ResultSrcE;
            RD_M        <= RD_E;
            PCPlus4M    <= PCPlus4E;
            WriteDataM  <= fwdB;
            ALU_ResultM <= aluResult;
        end
    end

endmodule
